// File: rtl/ws_psum_deskew_collector_pkg.sv
// Shared widths and helpers for the partial-sum deskew collector.
package ws_psum_deskew_collector_pkg;

  // Counter widths for the accepted and dropped vector counts.
  localparam int VEC_CNT_W  = 16;
  localparam int DROP_CNT_W = 8;

  // Each sum lane is twice the PE operand width.
  function automatic int sum_w(input int d_w);
    return 2 * d_w;
  endfunction

  // Lowest bit index of a lane inside a packed lane vector.
  function automatic int lane_lo(input int lane, input int d_w);
    return lane * sum_w(d_w);
  endfunction

endpackage

// File: rtl/ws_psum_deskew_collector_if.sv
// Input lanes from the PE array and the aligned-vector output handshake.
//
// Handshake: out_valid means the FIFO head holds an aligned vector and
// out_vec is stable while out_valid && !out_ready. A transfer happens on a
// rising edge where out_valid && out_ready; out_ready while out_valid=0 is
// ignored. The input side has no ready: the array cannot be stalled.
interface ws_psum_deskew_collector_if
  import ws_psum_deskew_collector_pkg::*;
#(
  parameter int D_W  = 8,
  parameter int COLS = 4
) ();
  localparam int VEC_W = COLS * sum_w(D_W);

  logic             in_valid;
  logic [VEC_W-1:0] in_sum;
  logic             out_valid;
  logic             out_ready;
  logic [VEC_W-1:0] out_vec;

  // Producer/consumer side (array plus result writer).
  modport master (
    output in_valid, in_sum, out_ready,
    input  out_valid, out_vec
  );

  // Collector side.
  modport slave (
    input  in_valid, in_sum, out_ready,
    output out_valid, out_vec
  );
endinterface

// File: rtl/ws_psum_deskew_collector_vec_fifo.sv
// Small synchronous FIFO holding aligned result vectors.
module ws_vec_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             push_ok;
  logic             pop_ok;

  // A pop frees the slot a same-cycle push into a full FIFO will reuse.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign head  = mem[rd_ptr];

  // Storage is written only on an accepted push; no reset needed on data.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/ws_psum_deskew_collector.sv
// Re-aligns skewed bottom-row partial sums into whole vectors and buffers them.
module ws_psum_deskew_collector
  import ws_psum_deskew_collector_pkg::*;
#(
  parameter int D_W        = 8,
  parameter int COLS       = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int AF_LEVEL   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  ws_psum_deskew_collector_if.slave    bus,
  input  logic                         clear_flags,
  output logic                         almost_full,
  output logic                         overflow,
  output logic [VEC_CNT_W-1:0]         vec_count,
  output logic [DROP_CNT_W-1:0]        drop_count
);
  localparam int SUM_W = sum_w(D_W);
  localparam int VEC_W = COLS * SUM_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [SUM_W-1:0] aligned [COLS];
  logic [VEC_W-1:0] aligned_vec;
  logic             vec_done;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [VEC_W-1:0] fifo_head;
  logic             pop;
  logic             accept;
  logic             drop;
  logic [CNT_W-1:0] occ_next;

  // Lane c waits COLS-1-c cycles so every lane lines up with the last one.
  for (genvar c = 0; c < COLS; c++) begin : g_lane
    localparam int L = COLS - 1 - c;
    if (L == 0) begin : g_direct
      assign aligned[c] = bus.in_sum[lane_lo(c, D_W) +: SUM_W];
    end else begin : g_delay
      logic [SUM_W-1:0] sr [L];
      // Free-running shift chain; data moves every cycle regardless of valid.
      always_ff @(posedge clk) begin
        if (!rst) begin
          for (int i = 0; i < L; i++) sr[i] <= '0;
        end else begin
          sr[0] <= bus.in_sum[lane_lo(c, D_W) +: SUM_W];
          for (int i = 1; i < L; i++) sr[i] <= sr[i-1];
        end
      end
      assign aligned[c] = sr[L-1];
    end
  end

  // Pack the aligned lanes back into the input lane order.
  always_comb begin
    aligned_vec = '0;
    for (int c = 0; c < COLS; c++) aligned_vec[c*SUM_W +: SUM_W] = aligned[c];
  end

  // The valid pipe tracks when the last lane of a vector has arrived.
  if (COLS == 1) begin : g_no_vpipe
    assign vec_done = bus.in_valid;
  end else begin : g_vpipe
    logic vpipe [COLS-1];
    // Shift in_valid alongside the longest data chain.
    always_ff @(posedge clk) begin
      if (!rst) begin
        for (int i = 0; i < COLS - 1; i++) vpipe[i] <= 1'b0;
      end else begin
        vpipe[0] <= bus.in_valid;
        for (int i = 1; i < COLS - 1; i++) vpipe[i] <= vpipe[i-1];
      end
    end
    assign vec_done = vpipe[COLS-2];
  end

  assign pop    = bus.out_valid && bus.out_ready;
  assign accept = vec_done && (!fifo_full || pop);
  assign drop   = vec_done && !accept;

  ws_vec_fifo #(
    .WIDTH (VEC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (pop),
    .din   (aligned_vec),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Head is only meaningful while the FIFO holds data; show zero otherwise.
  assign bus.out_valid = !fifo_empty;
  assign bus.out_vec   = fifo_empty ? '0 : fifo_head;

  // Occupancy after this edge, used to register almost_full without lag.
  always_comb begin
    occ_next = fifo_count;
    if (accept && !pop) occ_next = fifo_count + CNT_W'(1);
    if (pop && !accept) occ_next = fifo_count - CNT_W'(1);
  end

  // Flags and saturating counters; a drop outranks a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      almost_full <= 1'b0;
      overflow    <= 1'b0;
      vec_count   <= '0;
      drop_count  <= '0;
    end else begin
      almost_full <= (int'(occ_next) >= AF_LEVEL);
      if (accept && (vec_count != '1)) vec_count <= vec_count + VEC_CNT_W'(1);
      if (drop) begin
        overflow <= 1'b1;
        if (clear_flags)             drop_count <= DROP_CNT_W'(1);
        else if (drop_count != '1)   drop_count <= drop_count + DROP_CNT_W'(1);
      end else if (clear_flags) begin
        overflow   <= 1'b0;
        drop_count <= '0;
      end
    end
  end
endmodule

// File: tb/tb_ws_psum_deskew_collector.sv
// Bench for the partial-sum deskew collector: directed table, corner
// sequences and randomized traffic against a queue-based reference.
module tb_ws_psum_deskew_collector;
  localparam int D_W   = 8;
  localparam int COLS  = 4;
  localparam int DEPTH = 4;
  localparam int AF    = 2;
  localparam int SUM_W = 2 * D_W;
  localparam int VEC_W = COLS * SUM_W;

  typedef logic [VEC_W-1:0] vec_t;

  typedef struct {
    bit          iv;
    bit          rdy;
    bit          exp_valid;
    vec_t        exp_vec;
    logic [15:0] exp_vc;
  } row_t;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        clear_flags;
  logic        almost_full;
  logic        overflow;
  logic [15:0] vec_count;
  logic [7:0]  drop_count;

  ws_psum_deskew_collector_if #(.D_W(D_W), .COLS(COLS)) bus ();

  ws_psum_deskew_collector #(
    .D_W(D_W), .COLS(COLS), .FIFO_DEPTH(DEPTH), .AF_LEVEL(AF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .clear_flags (clear_flags),
    .almost_full (almost_full),
    .overflow    (overflow),
    .vec_count   (vec_count),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  vec_t exp_q[$];        // aligned vectors expected in the FIFO, head first
  vec_t vec_at[int];     // vector launched in a given cycle
  int   m_vc;
  int   m_dc;
  bit   m_ovf;
  int   last_rst;
  int   cyc;
  int   n_tests;
  int   n_fail;

  task automatic chk(input string name, input vec_t act, input vec_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Compare every output against the model's view of the current cycle.
  task automatic check_model();
    chk("m_out_valid", vec_t'(bus.out_valid), vec_t'(exp_q.size() > 0));
    if (exp_q.size() > 0) chk("m_out_vec", bus.out_vec, exp_q[0]);
    chk("m_almost_full", vec_t'(almost_full), vec_t'(exp_q.size() >= AF));
    chk("m_overflow", vec_t'(overflow), vec_t'(m_ovf));
    chk("m_vec_count", vec_t'(vec_count), vec_t'(m_vc));
    chk("m_drop_count", vec_t'(drop_count), vec_t'(m_dc));
  endtask

  // ---------------- driver ----------------
  // Drives one cycle: launches vector v when iv, feeds each lane with the
  // skew of the vector it belongs to, advances the model, then checks.
  task automatic run_cycle(input bit rst_v, input bit iv, input vec_t v,
                           input bit rdy, input bit clr);
    vec_t sum;
    vec_t tmp;
    int   src;
    bit   pop;
    bit   comp;
    if (!rst_v) last_rst = cyc;
    if (iv) vec_at[cyc] = v;
    for (int c = 0; c < COLS; c++) begin
      src = cyc - c;
      if (vec_at.exists(src)) begin
        tmp = vec_at[src];
        sum[c*SUM_W +: SUM_W] = tmp[c*SUM_W +: SUM_W];
      end else begin
        sum[c*SUM_W +: SUM_W] = SUM_W'($urandom);
      end
    end
    rst           = rst_v;
    bus.in_valid  = iv;
    bus.in_sum    = sum;
    bus.out_ready = rdy;
    clear_flags   = clr;
    if (!rst_v) begin
      exp_q.delete();
      m_vc  = 0;
      m_dc  = 0;
      m_ovf = 0;
    end else begin
      pop  = (exp_q.size() > 0) && rdy;
      src  = cyc - (COLS - 1);
      comp = vec_at.exists(src) && (src > last_rst);
      if (pop) tmp = exp_q.pop_front();
      if (clr) begin
        m_ovf = 0;
        m_dc  = 0;
      end
      if (comp) begin
        if (exp_q.size() < DEPTH) begin
          exp_q.push_back(vec_at[src]);
          if (m_vc < 65535) m_vc++;
        end else begin
          m_ovf = 1;
          if (m_dc < 255) m_dc++;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_model();
  endtask

  task automatic idle(input bit rdy, input bit clr);
    run_cycle(1'b1, 1'b0, '0, rdy, clr);
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    for (int c = 0; c < COLS; c++) v[c*SUM_W +: SUM_W] = SUM_W'($urandom);
    return v;
  endfunction

  function automatic vec_t tag_vec(input int k);
    vec_t v;
    for (int c = 0; c < COLS; c++) v[c*SUM_W +: SUM_W] = SUM_W'(16 * k + c);
    return v;
  endfunction

  // ---------------- test sequence ----------------
  row_t tbl[6];
  vec_t v0_hold;

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    cyc      = 0;
    last_rst = 0;
    m_vc     = 0;
    m_dc     = 0;
    m_ovf    = 0;

    // Single-vector table: each row describes the cycle after it is driven.
    tbl[0] = '{1'b1, 1'b1, 1'b0, '0, 16'd0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, '0, 16'd0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, '0, 16'd0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 64'h0400_0300_0200_0100, 16'd1};
    tbl[4] = '{1'b0, 1'b1, 1'b0, '0, 16'd1};
    tbl[5] = '{1'b0, 1'b1, 1'b0, '0, 16'd1};

    // Reset held two cycles with in_valid=1: everything zero, nothing pushed.
    run_cycle(1'b0, 1'b1, rand_vec(), 1'b1, 1'b0);
    run_cycle(1'b0, 1'b1, rand_vec(), 1'b1, 1'b0);
    chk("rst_out_valid", vec_t'(bus.out_valid), '0);
    chk("rst_out_vec", bus.out_vec, '0);
    chk("rst_almost_full", vec_t'(almost_full), '0);
    chk("rst_overflow", vec_t'(overflow), '0);
    chk("rst_vec_count", vec_t'(vec_count), '0);
    chk("rst_drop_count", vec_t'(drop_count), '0);
    for (int i = 0; i < 5; i++) idle(1'b1, 1'b0);
    chk("rst_no_push", vec_t'(vec_count), '0);

    // Single vector from the table.
    for (int i = 0; i < 6; i++) begin
      run_cycle(1'b1, tbl[i].iv, 64'h0400_0300_0200_0100, tbl[i].rdy, 1'b0);
      chk("tbl_out_valid", vec_t'(bus.out_valid), vec_t'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) chk("tbl_out_vec", bus.out_vec, tbl[i].exp_vec);
      chk("tbl_vec_count", vec_t'(vec_count), vec_t'(tbl[i].exp_vc));
    end

    // Back-to-back vectors, consumer always ready.
    for (int k = 0; k < 6; k++) run_cycle(1'b1, 1'b1, tag_vec(k), 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) idle(1'b1, 1'b0);
    chk("b2b_overflow", vec_t'(overflow), '0);
    chk("b2b_vec_count", vec_t'(vec_count), vec_t'(7));

    // Back-pressure: six vectors into a four-deep FIFO, two dropped.
    run_cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) run_cycle(1'b1, 1'b1, tag_vec(k + 8), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) idle(1'b0, 1'b0);
    v0_hold = tag_vec(8);
    chk("bp_overflow", vec_t'(overflow), vec_t'(1));
    chk("bp_drop_count", vec_t'(drop_count), vec_t'(2));
    chk("bp_almost_full", vec_t'(almost_full), vec_t'(1));
    chk("bp_head_held", bus.out_vec, v0_hold);
    for (int i = 0; i < 6; i++) idle(1'b1, 1'b0);
    chk("bp_delivered", vec_t'(vec_count), vec_t'(4));
    chk("bp_empty", vec_t'(bus.out_valid), '0);

    // Full FIFO with a pop in the same cycle as a push: no drop.
    run_cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) run_cycle(1'b1, 1'b1, tag_vec(k + 1), 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b0);
    chk("fp_drop_count", vec_t'(drop_count), '0);
    chk("fp_vec_count", vec_t'(vec_count), vec_t'(5));
    chk("fp_almost_full", vec_t'(almost_full), vec_t'(1));
    chk("fp_head", bus.out_vec, tag_vec(2));

    // clear_flags after a drop, then clear coinciding with a drop.
    run_cycle(1'b1, 1'b1, tag_vec(9), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b0, 1'b0);
    chk("cf_overflow_set", vec_t'(overflow), vec_t'(1));
    chk("cf_drop_one", vec_t'(drop_count), vec_t'(1));
    idle(1'b0, 1'b1);
    chk("cf_overflow_clr", vec_t'(overflow), '0);
    chk("cf_drop_clr", vec_t'(drop_count), '0);
    run_cycle(1'b1, 1'b1, tag_vec(10), 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b1);
    chk("cf_drop_wins_ovf", vec_t'(overflow), vec_t'(1));
    chk("cf_drop_wins_cnt", vec_t'(drop_count), vec_t'(1));

    // Randomized traffic with occasional clears and resets.
    for (int i = 0; i < 500; i++) begin
      run_cycle(($urandom_range(0, 99) >= 2), ($urandom_range(0, 1) == 1),
                rand_vec(), ($urandom_range(0, 9) < 6),
                ($urandom_range(0, 99) < 5));
    end
    for (int i = 0; i < 8; i++) idle(1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ws_psum_deskew_collector.md
Name: ws_psum_deskew_collector

Overview:
- Downstream stage of the weight-stationary PE array. Consumes the skewed bottom-row partial sums (one out_sum per column, column c lagging column 0 by c cycles).
- Re-aligns each column with a per-column delay line and pushes each complete result vector into a small FIFO.
- Presents the FIFO to the result writer through a valid/ready handshake. The array cannot stall, so the block raises almost_full early and records overflow rather than back-pressuring.

Parameters:
- D_W, 8, PE operand width; each sum lane is 2*D_W bits.
- COLS, 4, array columns / sum lanes (>=1).
- FIFO_DEPTH, 4, aligned-vector FIFO entries (power of 2, >=2).
- AF_LEVEL, 2, occupancy at or above which almost_full asserts.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- rst, input, 1, synchronous active-low reset; rst==0 at a rising edge resets all state.
- in_valid, input, 1, column-0 sum of a new vector is present this cycle.
- in_sum, input, COLS*2*D_W, bottom-row out_sum lanes; lane c = bits [(c+1)*2*D_W-1 : c*2*D_W].
- out_valid, output, 1, FIFO head holds an aligned vector.
- out_ready, input, 1, consumer accepts the head this cycle.
- out_vec, output, COLS*2*D_W, aligned vector; same lane order as in_sum.
- almost_full, output, 1, FIFO occupancy >= AF_LEVEL.
- overflow, output, 1, sticky; an aligned vector was dropped.
- clear_flags, input, 1, synchronously clears overflow and drop_count.
- vec_count, output, 16, aligned vectors accepted into the FIFO; saturates at 0xFFFF.
- drop_count, output, 8, dropped vectors; saturates at 0xFF.

Behaviour:
Reset values
- Reset clears all delay lines, the valid pipe, the FIFO pointers and occupancy, all flags and all counters.
- After reset: out_valid=0, out_vec=0, almost_full=0, overflow=0, vec_count=0, drop_count=0.
- Reset mid-operation discards in-flight and buffered vectors; no partial vector is emitted afterwards.

Input timing
- Vector k: lane c is valid in cycle t_k+c, where t_k is the cycle in which in_valid=1.
- in_valid pulses for consecutive vectors may be back-to-back (one per cycle).

Deskew
- Lane c passes through a register chain of length COLS-1-c; lane COLS-1 is taken directly from the input.
- in_valid passes through a COLS-1 stage valid pipe.
- The aligned vector is complete in cycle t_k+COLS-1, when the valid-pipe output is 1.
- Delay lines shift every cycle regardless of valid; no arithmetic is performed and no width change is made.

FIFO push
- Push happens at the edge ending cycle t_k+COLS-1.
- Push is accepted if occupancy<FIFO_DEPTH, or if occupancy==FIFO_DEPTH and a pop occurs in the same cycle.
- Otherwise the vector is dropped: overflow is set and drop_count increments.

FIFO pop and output
- Pop happens when out_valid && out_ready. out_ready while out_valid=0 is ignored.
- There is no bypass path: with the FIFO empty, out_valid rises in cycle t_k+COLS, giving latency COLS.
- out_vec is held stable while out_valid && !out_ready.
- Simultaneous push and pop leaves occupancy unchanged.
- Pointers wrap modulo FIFO_DEPTH.

Flags and counters
- almost_full is registered from the next-state occupancy.
- vec_count increments on each accepted push.
- If clear_flags coincides with a drop, the drop wins: overflow=1 and drop_count=1.

Decomposition:
- ws_pkg holds SUM_W(D_W)=2*D_W, the lane slice helper, and the counter widths (16 for vec_count, 8 for drop_count).
- Sub-module ws_vec_fifo: synchronous FIFO with parameters WIDTH and DEPTH and signals push, pop, full, empty, count, head.
- The deskew delay lines and the valid pipe stay in the top module.

Test Plan:
- Reset: hold rst=0 for 2 cycles with in_valid=1 -> all outputs 0, no push afterwards.
- Single vector (COLS=4, D_W=8): in_valid at t=0; lane c=0x0100*(c+1) arriving at t=c; out_ready=1 -> out_valid only in cycle 4, out_vec lanes = {0x0400,0x0300,0x0200,0x0100} (lane 3..0), vec_count=1.
- Back-to-back: 6 vectors on consecutive cycles, lanes tagged 16*k+c, out_ready=1 -> 6 consecutive out_valid cycles starting at cycle 4, in order, no overflow.
- Back-pressure and overflow: out_ready=0, 6 vectors, FIFO_DEPTH=4 -> almost_full from the 2nd push, overflow=1, drop_count=2, head = vector 0 and held stable; then out_ready=1 -> exactly vectors 0..3 delivered.
- Full with simultaneous pop: FIFO full, out_ready=1 in the same cycle as a push -> push accepted, no drop, occupancy remains 4.
- clear_flags: after overflow, pulse clear_flags -> overflow=0, drop_count=0; repeat with a drop in the same cycle -> overflow=1, drop_count=1.
